// File: rtl/fp_ctrl_pkg.sv
// Shared types for the FP issue controller: the FPU tag layout and FSM states.
package fp_ctrl_pkg;

  localparam int FREG_AW = 5;

  // Tag carried through the FPU so the result knows where to land.
  typedef struct packed {
    logic               fwb;
    logic [FREG_AW-1:0] rd;
  } fp_tag_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fp_ctrl_state_e;

  // Build the tag sent along with an issued op.
  function automatic fp_tag_t make_tag(input logic fwb, input logic [FREG_AW-1:0] rd);
    fp_tag_t t;
    t.fwb = fwb;
    t.rd  = rd;
    return t;
  endfunction

endpackage

// File: rtl/fp_issue_ctrl_chk.sv
// Simulation-only invariants on the issue controller's bookkeeping.
module fp_issue_ctrl_chk
  import fp_ctrl_pkg::*;
#(
  parameter int CW      = 3,
  parameter int MAX_OUT = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic               out_fire_i,
  input logic               issue_fire_i,
  input logic [CW-1:0]      count_i,
  input logic               set_en_i,
  input logic [FREG_AW-1:0] set_addr_i,
  input logic               clr_en_i,
  input logic [FREG_AW-1:0] clr_addr_i
);

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_fire_i && !issue_fire_i) |-> (count_i != {CW{1'b0}}));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_i <= CW'(MAX_OUT));

  a_no_set_clr_same_bit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (set_en_i && clr_en_i) |-> (set_addr_i != clr_addr_i));

endmodule

// File: rtl/fp_scoreboard.sv
// One pending-write bit per FP register; flags RAW/WAW hazards for the
// op currently at the issue port.
module fp_scoreboard
  import fp_ctrl_pkg::*;
#(
  parameter int NUM_FREGS = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               set_en_i,
  input  logic [FREG_AW-1:0] set_addr_i,
  input  logic               clr_en_i,
  input  logic [FREG_AW-1:0] clr_addr_i,
  input  logic               clear_all_i,
  input  logic [3*FREG_AW-1:0] rs_i,
  input  logic [2:0]         rs_used_i,
  input  logic [FREG_AW-1:0] rd_i,
  input  logic               fwb_i,
  output logic               hazard_o
);

  localparam logic [NUM_FREGS-1:0] ONE_HOT0 = {{(NUM_FREGS-1){1'b0}}, 1'b1};

  logic [NUM_FREGS-1:0] sb_r;
  logic [NUM_FREGS-1:0] sb_nxt_s;
  logic [NUM_FREGS-1:0] set_mask_s;
  logic [NUM_FREGS-1:0] clr_mask_s;
  logic                 rs_haz_s;

  // Next scoreboard value: clear first, then set, so a same-edge set wins.
  always_comb begin
    set_mask_s = set_en_i ? (ONE_HOT0 << set_addr_i) : {NUM_FREGS{1'b0}};
    clr_mask_s = clr_en_i ? (ONE_HOT0 << clr_addr_i) : {NUM_FREGS{1'b0}};
    sb_nxt_s   = clear_all_i ? {NUM_FREGS{1'b0}} : ((sb_r & ~clr_mask_s) | set_mask_s);
  end

  // Scoreboard state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sb_r <= {NUM_FREGS{1'b0}};
    else         sb_r <= sb_nxt_s;
  end

  // RAW check across the three (optionally used) sources.
  always_comb begin
    rs_haz_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rs_haz_s = rs_haz_s | (rs_used_i[k] & sb_r[rs_i[k*FREG_AW +: FREG_AW]]);
    end
  end

  // WAW only matters when the op writes the FP register file.
  assign hazard_o = rs_haz_s | (fwb_i & sb_r[rd_i]);

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issues decoded FP ops to the FPU, tracks in-flight destinations, and
// writes returned results back one cycle after the FPU hands them over.
module fp_issue_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int DATAWIDTH       = 32,
  parameter int NUM_FREGS       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [FREG_AW-1:0]                   req_rd_i,
  input  logic [3*FREG_AW-1:0]                 req_rs_i,
  input  logic [2:0]                           req_rs_used_i,
  input  logic                                 req_fwb_i,
  output logic                                 fpu_in_valid_o,
  input  logic                                 fpu_in_ready_i,
  output logic [FREG_AW:0]                     fpu_tag_o,
  input  logic                                 fpu_out_valid_i,
  output logic                                 fpu_out_ready_o,
  input  logic [FREG_AW:0]                     fpu_tag_i,
  input  logic [DATAWIDTH-1:0]                 fpu_result_i,
  input  logic                                 flush_i,
  output logic                                 fpu_flush_o,
  output logic                                 wb_en_o,
  output logic                                 int_wb_o,
  output logic [FREG_AW-1:0]                   wb_addr_o,
  output logic [DATAWIDTH-1:0]                 wb_data_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 busy_o
);

  localparam int            CW      = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};

  fp_ctrl_state_e       state_r, state_nxt_s;
  logic [CW-1:0]        count_r, count_nxt_s;
  logic                 wb_en_r, int_wb_r;
  logic [FREG_AW-1:0]   wb_addr_r;
  logic [DATAWIDTH-1:0] wb_data_r;
  logic                 hazard_s, issue_ok_s, issue_fire_s, out_fire_s;
  fp_tag_t              ret_tag_s;

  assign ret_tag_s       = fp_tag_t'(fpu_tag_i);
  assign issue_ok_s      = (state_r == RUN) & ~flush_i & ~hazard_s & (count_r < MAX_CNT);
  assign fpu_in_valid_o  = req_valid_i & issue_ok_s;
  assign req_ready_o     = fpu_in_ready_i & issue_ok_s;
  assign issue_fire_s    = req_valid_i & fpu_in_ready_i & issue_ok_s;
  assign fpu_tag_o       = make_tag(req_fwb_i, req_rd_i);
  assign fpu_out_ready_o = (state_r == RUN) & ~flush_i;
  assign out_fire_s      = fpu_out_valid_i & fpu_out_ready_o;
  assign fpu_flush_o     = flush_i;

  fp_scoreboard #(.NUM_FREGS(NUM_FREGS)) u_sb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .set_en_i    (issue_fire_s & req_fwb_i),
    .set_addr_i  (req_rd_i),
    .clr_en_i    (wb_en_r),
    .clr_addr_i  (wb_addr_r),
    .clear_all_i (flush_i),
    .rs_i        (req_rs_i),
    .rs_used_i   (req_rs_used_i),
    .rd_i        (req_rd_i),
    .fwb_i       (req_fwb_i),
    .hazard_o    (hazard_s)
  );

  // FSM next state: a flush always lands in (or stays in) FLUSH for a cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN:     state_nxt_s = flush_i ? FLUSH : RUN;
      FLUSH:   state_nxt_s = flush_i ? FLUSH : RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // In-flight count: simultaneous issue and retire cancel out.
  always_comb begin
    count_nxt_s = count_r;
    if (flush_i) begin
      count_nxt_s = {CW{1'b0}};
    end else if (issue_fire_s && !out_fire_s) begin
      count_nxt_s = count_r + ONE;
    end else if (!issue_fire_s && out_fire_s) begin
      count_nxt_s = count_r - ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FSM state and in-flight counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= RUN;
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Write-back stage: capture a returned result; a flush drops it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_en_r   <= 1'b0;
      int_wb_r  <= 1'b0;
      wb_addr_r <= {FREG_AW{1'b0}};
      wb_data_r <= {DATAWIDTH{1'b0}};
    end else if (flush_i) begin
      wb_en_r  <= 1'b0;
      int_wb_r <= 1'b0;
    end else begin
      wb_en_r  <= out_fire_s & ret_tag_s.fwb;
      int_wb_r <= out_fire_s & ~ret_tag_s.fwb;
      if (out_fire_s) begin
        wb_addr_r <= ret_tag_s.rd;
        wb_data_r <= fpu_result_i;
      end
    end
  end

  assign wb_en_o       = wb_en_r;
  assign int_wb_o      = int_wb_r;
  assign wb_addr_o     = wb_addr_r;
  assign wb_data_o     = wb_data_r;
  assign outstanding_o = count_r;
  assign busy_o        = (count_r != {CW{1'b0}}) | wb_en_r | int_wb_r | (state_r == FLUSH);

  fp_issue_ctrl_chk #(.CW(CW), .MAX_OUT(MAX_OUTSTANDING)) u_chk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .out_fire_i   (out_fire_s),
    .issue_fire_i (issue_fire_s),
    .count_i      (count_r),
    .set_en_i     (issue_fire_s & req_fwb_i),
    .set_addr_i   (req_rd_i),
    .clr_en_i     (wb_en_r),
    .clr_addr_i   (wb_addr_r)
  );

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Randomized bench for fp_issue_ctrl: the bench plays the FPU (a FIFO of
// issued ops) and keeps a register-level reference of the controller rules.
module tb_fp_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_fwb_i, fpu_in_ready_i, fpu_out_valid_i, flush_i;
  logic [4:0]  req_rd_i;
  logic [14:0] req_rs_i;
  logic [2:0]  req_rs_used_i;
  logic [5:0]  fpu_tag_i;
  logic [31:0] fpu_result_i;
  logic        req_ready_o, fpu_in_valid_o, fpu_out_ready_o, fpu_flush_o;
  logic        wb_en_o, int_wb_o, busy_o;
  logic [5:0]  fpu_tag_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic [2:0]  outstanding_o;

  fp_issue_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_i(req_rd_i), .req_rs_i(req_rs_i), .req_rs_used_i(req_rs_used_i),
    .req_fwb_i(req_fwb_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_tag_i(fpu_tag_i), .fpu_result_i(fpu_result_i),
    .flush_i(flush_i), .fpu_flush_o(fpu_flush_o),
    .wb_en_o(wb_en_o), .int_wb_o(int_wb_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] sb_m;
  int          cnt_m;
  logic        fl_m, wb_en_m, int_wb_m;
  logic [4:0]  wb_addr_m;
  logic [31:0] wb_data_m;
  logic [37:0] fpu_q[$];   // {tag, result} of ops inside the FPU, oldest first

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_m = 32'd0; cnt_m = 0; fl_m = 1'b0; wb_en_m = 1'b0; int_wb_m = 1'b0;
    wb_addr_m = 5'd0; wb_data_m = 32'd0;
    fpu_q.delete();
  endtask

  // One clock: drive at negedge, check after settling, advance reference at posedge.
  task automatic step(input logic v, input logic [4:0] rd, input logic [14:0] rs,
                      input logic [2:0] used, input logic fwb, input logic inr,
                      input logic outv, input logic fl);
    logic haz, ok, ov, iss, ofire;
    logic [37:0] head;
    ov = outv && (fpu_q.size() > 0);
    head = ov ? fpu_q[0] : {6'($urandom), $urandom};
    req_valid_i = v; req_rd_i = rd; req_rs_i = rs; req_rs_used_i = used; req_fwb_i = fwb;
    fpu_in_ready_i = inr; fpu_out_valid_i = ov; fpu_tag_i = head[37:32];
    fpu_result_i = head[31:0]; flush_i = fl;
    #1;
    haz = fwb && sb_m[rd];
    for (int k = 0; k < 3; k++) if (used[k] && sb_m[rs[k*5 +: 5]]) haz = 1'b1;
    ok = !fl_m && !fl && !haz && (cnt_m < 4);
    check_eq("req_ready", req_ready_o, inr & ok);
    check_eq("in_valid", fpu_in_valid_o, v & ok);
    check_eq("tag_out", fpu_tag_o, {fwb, rd});
    check_eq("out_ready", fpu_out_ready_o, !fl_m && !fl);
    check_eq("fpu_flush", fpu_flush_o, fl);
    check_eq("wb_en", wb_en_o, wb_en_m);
    check_eq("int_wb", int_wb_o, int_wb_m);
    check_eq("wb_addr", wb_addr_o, wb_addr_m);
    check_eq("wb_data", wb_data_o, wb_data_m);
    check_eq("outstanding", outstanding_o, cnt_m);
    check_eq("busy", busy_o, (cnt_m != 0) || wb_en_m || int_wb_m || fl_m);
    iss   = v && inr && ok;
    ofire = ov && !fl_m && !fl;
    @(posedge clk);
    if (fl) begin
      sb_m = 32'd0; cnt_m = 0; wb_en_m = 1'b0; int_wb_m = 1'b0;
      fpu_q.delete();
    end else begin
      if (wb_en_m) sb_m[wb_addr_m] = 1'b0;
      if (iss && fwb) sb_m[rd] = 1'b1;
      cnt_m = cnt_m + (iss ? 1 : 0) - (ofire ? 1 : 0);
      wb_en_m  = ofire && head[37];
      int_wb_m = ofire && !head[37];
      if (ofire) begin
        wb_addr_m = head[36:32];
        wb_data_m = head[31:0];
        void'(fpu_q.pop_front());
      end
      if (iss) fpu_q.push_back({fwb, rd, $urandom});
    end
    fl_m = fl;
    @(negedge clk);
  endtask

  task automatic idle(input logic fl);
    step(1'b0, 5'd0, 15'd0, 3'd0, 1'b0, 1'b1, 1'b0, fl);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_rd_i = 5'd0; req_rs_i = 15'd0; req_rs_used_i = 3'd0;
    req_fwb_i = 1'b0; fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0; fpu_tag_i = 6'd0;
    fpu_result_i = 32'd0; flush_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_wb_en", wb_en_o, 1'b0);
    check_eq("rst_int_wb", int_wb_o, 1'b0);
    check_eq("rst_wb_data", wb_data_o, 32'd0);
    check_eq("rst_outstanding", outstanding_o, 3'd0);
    check_eq("rst_busy", busy_o, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk);

    // First issue: rd=3 to FP file
    step(1'b1, 5'd3, 15'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("first_outstanding", outstanding_o, 3'd1);
    // Fill to the limit, then a fifth request must wait
    for (int i = 0; i < 4; i++) step(1'b1, 5'(10 + i), 15'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("max_outstanding", outstanding_o, 3'd4);
    step(1'b1, 5'd13, 15'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 5'd13, 15'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("refill_outstanding", outstanding_o, 3'd4);
    // Flush everything
    idle(1'b1);
    check_eq("flush_outstanding", outstanding_o, 3'd0);
    idle(1'b0);
    // Integer-side op rd=7, then a reader of 7 must not stall
    step(1'b1, 5'd7, 15'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd8, 15'd7, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("int_wb_pulse", int_wb_o, 1'b1);
    repeat (4) step(1'b0, 5'd0, 15'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes and one async reset
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        rst_ni = 1'b0;
        #1;
        check_eq("async_rst_outstanding", outstanding_o, 3'd0);
        check_eq("async_rst_busy", busy_o, 1'b0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
      end
      step($urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)),
           {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
           3'($urandom), $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
